// File: rtl/led_bar_pkg.sv
// led_bar_pkg: shared state encoding and count limits for the LED bar sequencer.
package led_bar_pkg;
    typedef enum logic [1:0] {MANUAL, RISE, FALL} state_t;
    localparam int COUNT_W = 5;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 5'd16;
endpackage

// File: rtl/led_bar_tick_gen.sv
// led_bar_tick_gen: free-running prescaler, one-cycle tick every TICK_DIV clocks.
module led_bar_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
    logic [W-1:0] cnt;
    assign tick = (cnt == LAST);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/led_bar_sequencer.sv
// led_bar_sequencer: 0..16 bar level, manual up/down or ping-pong auto sweep.
// Define LED_BAR_DEBOUNCE_EN to synchronise and edge-detect the buttons.
module led_bar_sequencer
    import led_bar_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               mode_auto,
    output logic [COUNT_W-1:0] current_count,
    output logic               at_max,
    output logic               at_min,
    output logic               sweep_dir
);
    logic               up, down, tick, step_up, step_dn, dir_nxt;
    logic [COUNT_W-1:0] manual_cnt, count_nxt;
    state_t             state, state_nxt;

`ifdef LED_BAR_DEBOUNCE_EN
    // [1:0] synchronise, [2] aligns the pulse to the third edge, [3] is edge history
    logic [3:0] up_sh, down_sh;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            up_sh   <= '0;
            down_sh <= '0;
        end else begin
            up_sh   <= {up_sh[2:0], btn_up};
            down_sh <= {down_sh[2:0], btn_down};
        end
    assign up   = up_sh[2] & ~up_sh[3];
    assign down = down_sh[2] & ~down_sh[3];
`else
    assign up   = btn_up;
    assign down = btn_down;
`endif

    led_bar_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign step_up    = up & ~down & (current_count != COUNT_MAX);
    assign step_dn    = down & ~up & (current_count != '0);
    assign manual_cnt = step_up ? current_count + 1'b1 :
                        step_dn ? current_count - 1'b1 : current_count;

    // Sweep direction on entry is chosen from the level the manual step produces
    always_comb begin
        state_nxt = state;
        count_nxt = current_count;
        case (state)
            MANUAL: begin
                count_nxt = manual_cnt;
                if (mode_auto) state_nxt = (manual_cnt < COUNT_MAX) ? RISE : FALL;
            end
            RISE:
                if (!mode_auto) state_nxt = MANUAL;
                else if (tick) begin
                    count_nxt = current_count + 1'b1;
                    if (count_nxt == COUNT_MAX) state_nxt = FALL;
                end
            FALL:
                if (!mode_auto) state_nxt = MANUAL;
                else if (tick) begin
                    count_nxt = current_count - 1'b1;
                    if (count_nxt == '0) state_nxt = RISE;
                end
            default: state_nxt = MANUAL;
        endcase
    end

    assign dir_nxt = (state_nxt == RISE) ? 1'b1 : (state_nxt == FALL) ? 1'b0 : sweep_dir;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state         <= MANUAL;
            current_count <= '0;
            at_max        <= 1'b0;
            at_min        <= 1'b1;
            sweep_dir     <= 1'b1;
        end else begin
            state         <= state_nxt;
            current_count <= count_nxt;
            at_max        <= (count_nxt == COUNT_MAX);
            at_min        <= (count_nxt == '0);
            sweep_dir     <= dir_nxt;
        end
endmodule

// File: tb/tb_led_bar_sequencer.sv
// tb_led_bar_sequencer: scoreboard bench with a behavioural level/direction model.
module tb_led_bar_sequencer;
    localparam int TD = 4;

    logic       clk = 0, rst = 1, btn_up = 0, btn_down = 0, mode_auto = 0;
    logic [4:0] current_count;
    logic       at_max, at_min, sweep_dir;

    led_bar_sequencer #(.TICK_DIV(TD)) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .mode_auto     (mode_auto),
        .current_count (current_count),
        .at_max        (at_max),
        .at_min        (at_min),
        .sweep_dir     (sweep_dir)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [4:0] c; logic mx; logic mn; logic dir;} obs_t;
    obs_t q[$];
    int   tests = 0, fails = 0;

    // Model: level, direction, whether sweeping, edges since reset
    int m_cnt = 0, m_k = 0;
    bit m_dir = 1, m_sweep = 0;
`ifdef LED_BAR_DEBOUNCE_EN
    bit [4:0] hu = 0, hd = 0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_k = 0; m_dir = 1; m_sweep = 0;
`ifdef LED_BAR_DEBOUNCE_EN
        hu = 0; hd = 0;
`endif
    endtask

    task automatic model(input bit u, input bit d, input bit a);
        bit tick, su, sd;
        m_k++;
        tick = (m_k % TD) == 0;
`ifdef LED_BAR_DEBOUNCE_EN
        hu = {hu[3:0], u}; hd = {hd[3:0], d};
        su = hu[3] & ~hu[4]; sd = hd[3] & ~hd[4];
`else
        su = u; sd = d;
`endif
        if (!m_sweep) begin
            if (su && !sd) m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
            else if (sd && !su) m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
            if (a) begin m_sweep = 1; m_dir = (m_cnt < 16); end
        end else if (!a) m_sweep = 0;
        else if (tick) begin
            m_cnt += m_dir ? 1 : -1;
            if (m_cnt == 16) m_dir = 0;
            else if (m_cnt == 0) m_dir = 1;
        end
    endtask

    // Called in the low phase; drives inputs for the coming rising edge
    task automatic cyc(input bit u, input bit d, input bit a);
        btn_up = u; btn_down = d; mode_auto = a;
        model(u, d, a);
        q.push_back('{c: 5'(m_cnt), mx: (m_cnt == 16), mn: (m_cnt == 0), dir: m_dir});
        @(negedge clk);
    endtask

    task automatic press(input bit u, input bit d);
        cyc(u, d, 0);
        repeat (4) cyc(0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1; btn_up = 0; btn_down = 0; mode_auto = 0;
        #1;
        chk({tag, " count"}, current_count, 0);
        chk({tag, " at_min"}, at_min, 1);
        chk({tag, " at_max"}, at_max, 0);
        chk({tag, " sweep_dir"}, sweep_dir, 1);
        model_reset();
        #1 rst = 0;
    endtask

    initial forever begin
        obs_t e;
        @(posedge clk); #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            tests++;
            if ({current_count, at_max, at_min, sweep_dir} !== e) begin
                fails++;
                $display("FAIL sb t=%0t count/max/min/dir got %0d/%b/%b/%b expected %0d/%b/%b/%b",
                         $time, current_count, at_max, at_min, sweep_dir, e.c, e.mx, e.mn, e.dir);
            end
        end
    end

    initial begin
        int n, base;
        bit a;
        @(negedge clk);
        do_reset("por");
        repeat (3) press(1, 0);
        chk("three up", current_count, 3);
        repeat (5) press(0, 1);
        chk("five down", current_count, 0);
        chk("five down at_min", at_min, 1);
        repeat (20) press(1, 0);
        chk("twenty up", current_count, 16);
        chk("twenty up at_max", at_max, 1);
        press(1, 0);
        chk("up at max", current_count, 16);
        repeat (9) press(0, 1);
        press(1, 1);
        chk("up+down at 7", current_count, 7);
        repeat (60) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

        do_reset("pre-sweep");
        repeat (TD * 36) cyc(0, 0, 1);
        chk("sweep bounce count", current_count, 4);
        chk("sweep bounce dir", sweep_dir, 1);
        n = 0;
        while (!(m_sweep && !m_dir && m_cnt == 9) && n < 400) begin cyc(0, 0, 1); n++; end
        if (n == 400) begin fails++; $display("FAIL reach 9 falling: timeout"); end
        repeat (3) cyc(0, 0, 0);
        chk("exit holds 9", current_count, 9);
        chk("exit holds dir", sweep_dir, 0);
        press(1, 0);
        chk("manual up to 10", current_count, 10);
        repeat (40) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);

        a = 1;
        repeat (400) begin
            if ($urandom_range(0, 15) == 0) a = ~a;
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a);
        end

        n = 0;
        while (!(m_sweep && m_cnt == 12) && n < 400) begin cyc(0, 0, 1); n++; end
        if (n == 400) begin fails++; $display("FAIL reach 12 sweeping: timeout"); end
        chk("pre-reset 12", current_count, 12);
        do_reset("mid-sweep");
        repeat (TD * 3) cyc(0, 0, 1);
        repeat (2) cyc(0, 0, 0);

        base = m_cnt;
        repeat (10) cyc(1, 0, 0);
        repeat (5) cyc(0, 0, 0);
`ifdef LED_BAR_DEBOUNCE_EN
        chk("held 10 cycles", current_count, base + 1);
`else
        chk("held 10 cycles", current_count, base + 10);
`endif
        @(posedge clk); #2;
        chk("scoreboard drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/led_bar_sequencer.md
LED_BAR_SEQUENCER -- requirements
Module: led_bar_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, meaning clock cycles per auto-sweep step (legal range 2..2^26).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port btn_up  input  1  manual step-up request.
REQ-005 SHALL have port btn_down  input  1  manual step-down request.
REQ-006 SHALL have port mode_auto  input  1  1 = ping-pong sweep, 0 = manual.
REQ-007 SHALL have port current_count  output  5  bar level 0..16, registered, feeds thermometer decoder.
REQ-008 SHALL have ports at_max and at_min  output  1 each  registered flags, count==16 and count==0 respectively.
REQ-009 SHALL have port sweep_dir  output  1  1 = rising, 0 = falling; registered.

Function
REQ-010 SHALL implement states MANUAL, RISE, FALL.
REQ-011 MANUAL: mode_auto=1 -> RISE if count<16, else FALL.
REQ-012 RISE: on step tick, count+1; if the count becomes 16 on that tick, -> FALL on the same edge.
REQ-013 FALL: on step tick, count-1; if the count becomes 0 on that tick, -> RISE on the same edge.
REQ-014 RISE/FALL: mode_auto=0 -> MANUAL; count held at its current value; any coincident tick is ignored.
REQ-015 In MANUAL, an up step SHALL increment count, saturating at 16.
REQ-016 In MANUAL, a down step SHALL decrement count, saturating at 0.
REQ-017 In MANUAL, coincident up and down steps SHALL leave count unchanged.
REQ-018 In RISE/FALL, button steps SHALL be ignored.
REQ-019 The step tick SHALL be a one-cycle pulse, asserted when the prescaler counter equals TICK_DIV-1; the counter then wraps to 0.
REQ-020 The prescaler SHALL be free-running and SHALL NOT restart on mode change.
REQ-021 Count SHALL never leave 0..16; values 17..31 are unreachable.
REQ-022 at_max, at_min and sweep_dir SHALL be updated on the same edge as count.
REQ-023 sweep_dir SHALL be 1 in RISE, 0 in FALL, and hold its last value in MANUAL.

Reset
REQ-024 rst=1 SHALL asynchronously force: state MANUAL, current_count 0, at_min 1, at_max 0, sweep_dir 1, prescaler 0, and any synchroniser/edge flops 0.
REQ-025 Reset asserted mid-sweep SHALL take effect immediately; after release, the first tick occurs TICK_DIV cycles later.

Configuration
REQ-026 Macro LED_BAR_DEBOUNCE_EN defined: btn_up and btn_down SHALL each pass a 2-flop synchroniser plus rising-edge detector; one step per press regardless of hold length; count changes on the 3rd rising edge after the edge that first samples the button high.
REQ-027 Macro LED_BAR_DEBOUNCE_EN undefined: btn_up and btn_down SHALL be treated as synchronous one-cycle strobes; count changes on the edge that samples the strobe high; a held button steps once per cycle.

Structure
REQ-028 A shared package led_bar_pkg SHALL hold the state enum (MANUAL/RISE/FALL), COUNT_W=5 and COUNT_MAX=16.
REQ-029 The prescaler SHALL be sub-module led_bar_tick_gen (parameter TICK_DIV; ports clk, rst, tick).

Verification
REQ-030 Reset then manual steps: reset, 3 up presses -> count 3; 5 down presses -> count 0, at_min=1.
REQ-031 Saturation: 20 up presses -> count 16, at_max=1; next up press -> count stays 16.
REQ-032 Auto sweep, TICK_DIV=4: mode_auto=1 from count 0 -> count +1 every 4 cycles to 16; next tick 15, sweep_dir=0; continues to 0, then rises again.
REQ-033 Mode exit, TICK_DIV=4: drop mode_auto at count 9 in FALL -> count holds 9; up press -> 10; ignored-button check: btn_up during sweep -> no extra step.
REQ-034 Simultaneous events: up+down same cycle in MANUAL at count 7 -> stays 7; rst asserted mid-sweep at count 12 -> count 0 without waiting for a clock edge.
REQ-035 Macro build check: with LED_BAR_DEBOUNCE_EN, btn_up held 10 cycles -> +1 after 3 edges; without it -> +10.
